ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage that consumes the decoded control and operand bundle registered by the decode/execute pipeline register and produces the execute/memory bundle. Single-cycle ALU operations complete in one clock. Multiply is a multi-cycle sequential operation that raises `stall` to hold upstream. Sits between the ID/EX register and data memory.

## Interface
- `MUL_CYCLES`, 32, iterations of the shift-add multiplier; fixed at 32 for 32-bit operands.
- `clk` in 1: rising-edge clock.
- `s` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous; kills the current execute result.
- `rf_wre`, `dm_wre` in 1 each: register-file and data-memory write enables from ID/EX.
- `m1sele` in 1: operand B select; 0 = `rtE`, 1 = `exte`.
- `m2sele` in 1: operand A select; 0 = `rsE`, 1 = 32'b0.
- `m3sele` in 1: writeback select; passed through unchanged.
- `ALUope` in 3: operation code.
- `exte`, `rsE`, `rtE`, `rdE` in 32 each: immediate, operands, destination word.
- `rf_wrm`, `dm_wrm`, `m3selm` out 1 each: registered control to MEM.
- `aluM` out 32: registered result.
- `rtM`, `rdM` out 32 each: registered store data and destination word.
- `zeroM` out 1: registered flag, set when `aluM` is 0.
- `stall` out 1: combinational hold request to the upstream enable.

## Operation
- ALUope codes:
  - 000 add, 001 sub, 010 and, 011 or, 100 xor.
  - 101 signed set-less-than, giving 1 or 0.
  - 110 sll A by B[4:0].
  - 111 mul, giving the low 32 bits of A*B with wrap-around.
- Add and sub wrap modulo 2^32. No overflow detection.
- States:
  - IDLE: a single-cycle op loads the output register every edge.
  - IDLE → BUSY: `ALUope`=111 and `rf_wre`=1. The edge latches A, B and the bundle, and clears the accumulator and `cnt`.
  - A mul op with `rf_wre`=0 is a nop: result 0, no stall.
  - BUSY: each edge adds B<<cnt to the accumulator when A[cnt]=1, then increments `cnt`.
  - BUSY → IDLE: at the edge ending the `cnt`=31 cycle, the final product and the latched bundle load the output register.
- `stall` = (IDLE and mul started) or (BUSY and `cnt`≠31).
- Bubble while `stall`=1:
  - Output register loads `rf_wrm`=`dm_wrm`=`m3selm`=0 and all data 0.
  - `zeroM`=1.
  - MEM therefore never sees a duplicate.
- `flush` priority:
  - `flush`=1 overrides everything: output loads a bubble, FSM returns to IDLE, `cnt` clears.
  - `flush` and the mul-start condition in the same cycle: flush wins, and no stall occurs in the next cycle.
- Reset (`s`=0, any time, including mid-multiply):
  - All outputs 0, `zeroM` 0, `stall` 0.
  - FSM IDLE, `cnt` 0, accumulator 0.

## Timing
- Single-cycle op presented in cycle n: outputs valid in cycle n+1.
- Mul presented in cycle 0:
  - `stall`=1 in cycles 0–31, 0 in cycle 32.
  - Result valid in cycle 33.
- Upstream advances at the edge ending cycle 32. The held mul bundle is not re-issued because the FSM is in BUSY at that edge.
- Back-to-back muls: the second starts in cycle 33, so 33 cycles per multiply.
- `stall` depends only on registered state plus `ALUope`, `rf_wre`, `flush`. No path from `rsE`/`rtE` data.

## Configuration
- `EX_MUL_EN` defined: multiplier, BUSY state and `stall` logic compiled in.
- `EX_MUL_EN` undefined:
  - ALUope 111 returns 0 in one cycle.
  - `stall` is tied to 0.
  - No accumulator or counter flops.

## Structure
- Shared package `ex_pkg`:
  - ALUop code constants and an ALUop enum.
  - FSM state typedef (IDLE, BUSY).
  - `MUL_CYCLES`.
- Sub-module `ex_mul_seq`: shift-add multiplier with start/flush/done, owning `cnt` and the accumulator. Instantiated only under `EX_MUL_EN`.
- Combinational ALU and the output register live in `ex_stage`.

## Test plan
- Reset mid-multiply:
  - Stimulus: start 7*9, assert `s`=0 in cycle 10.
  - Response: all outputs and `stall` are 0 immediately; after release, the next add op works in one cycle.
- Single-cycle ops:
  - Stimulus: rsE=0xFFFFFFFF, rtE=1, add.
  - Response: aluM=0, zeroM=1 next cycle.
  - Stimulus: slt with rsE=0x80000000, rtE=0.
  - Response: aluM=1.
- Immediate and zero select:
  - Stimulus: m1sele=1, m2sele=1, exte=0x1234, or.
  - Response: aluM=0x1234, rtM=rtE, m3selm=m3sele.
- Multiply:
  - Stimulus: A=0x10001, B=0x10001.
  - Response: stall high cycles 0–31; cycle 33 aluM=0x00020001, rf_wrm=1; bubbles in cycles 1–32.
- Flush during multiply:
  - Stimulus: flush in cycle 15 of a multiply.
  - Response: stall 0 next cycle; output is a bubble; a following sub 5−3 gives aluM=2.
- Multiply with writes disabled (and `EX_MUL_EN` off):
  - Stimulus: mul with rf_wre=0.
  - Response: no stall, aluM=0.
  - Build with `EX_MUL_EN` undefined: mul gives aluM=0 in one cycle, stall never asserts.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: ALU op codes, multiplier FSM states and bundles.
// The optional sequential multiplier is enabled with the EX_MUL_EN macro.
package ex_pkg;

    localparam int MUL_CYCLES = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_MUL = 3'b111;

    typedef enum logic [2:0] {
        OP_ADD = ALU_ADD,
        OP_SUB = ALU_SUB,
        OP_AND = ALU_AND,
        OP_OR  = ALU_OR,
        OP_XOR = ALU_XOR,
        OP_SLT = ALU_SLT,
        OP_SLL = ALU_SLL,
        OP_MUL = ALU_MUL
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mul_state_e;

    // Control and pass-through data that travel with a result into MEM.
    typedef struct packed {
        logic        rf_wr;
        logic        dm_wr;
        logic        m3sel;
        logic [31:0] rt;
        logic [31:0] rd;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [31:0] alu;
        logic        zero;
    } ex_mem_t;

    // Only a mul that actually writes the register file starts the multiplier.
    function automatic logic is_mul_req(input logic [2:0] op, input logic rf_we);
        return (op == ALU_MUL) && rf_we;
    endfunction

endpackage

// File: rtl/ex_mul_seq.sv
// Shift-add multiplier: one partial product per clock, MUL_CYCLES clocks per multiply.
// product_o is the finished low word only during the cycle where last_o is high.
module ex_mul_seq
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        s,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        last_o,
    output logic [31:0] product_o
);

    mul_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] addend;

    assign addend    = a_q[cnt_q] ? (b_q << cnt_q) : 32'd0;
    assign busy_o    = (state_q == ST_BUSY);
    assign last_o    = busy_o && (cnt_q == 5'(MUL_CYCLES - 1));
    assign product_o = acc_q + addend;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            cnt_d   = 5'd0;
            acc_d   = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_BUSY;
                        a_d     = a_i;
                        b_d     = b_i;
                        acc_d   = 32'd0;
                        cnt_d   = 5'd0;
                    end
                end
                ST_BUSY: begin
                    acc_d = acc_q + addend;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'(MUL_CYCLES - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge s) begin
        if (!s) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: combinational ALU plus the EX/MEM output register.
// Define EX_MUL_EN to build in the multi-cycle multiplier and its stall logic.
module ex_stage
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        s,
    input  logic        flush,
    input  logic        rf_wre,
    input  logic        dm_wre,
    input  logic        m1sele,
    input  logic        m2sele,
    input  logic        m3sele,
    input  logic [2:0]  ALUope,
    input  logic [31:0] exte,
    input  logic [31:0] rsE,
    input  logic [31:0] rtE,
    input  logic [31:0] rdE,
    output logic        rf_wrm,
    output logic        dm_wrm,
    output logic        m3selm,
    output logic [31:0] aluM,
    output logic [31:0] rtM,
    output logic [31:0] rdM,
    output logic        zeroM,
    output logic        stall
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] alu_res;
    ctl_t        ctl_in;
    ex_mem_t     alu_out;
    ex_mem_t     bubble;
    ex_mem_t     out_q, out_d;
    logic        mul_req;

    assign op_a    = m2sele ? 32'd0 : rsE;
    assign op_b    = m1sele ? exte  : rtE;
    assign mul_req = is_mul_req(ALUope, rf_wre);

    assign ctl_in.rf_wr = rf_wre;
    assign ctl_in.dm_wr = dm_wre;
    assign ctl_in.m3sel = m3sele;
    assign ctl_in.rt    = rtE;
    assign ctl_in.rd    = rdE;

    // Mul is handled by the sequential unit; here it only yields 0 (nop or disabled build).
    always_comb begin
        alu_res = 32'd0;
        case (alu_op_e'(ALUope))
            OP_ADD:  alu_res = op_a + op_b;
            OP_SUB:  alu_res = op_a - op_b;
            OP_AND:  alu_res = op_a & op_b;
            OP_OR:   alu_res = op_a | op_b;
            OP_XOR:  alu_res = op_a ^ op_b;
            OP_SLT:  alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
            OP_SLL:  alu_res = op_a << op_b[4:0];
            OP_MUL:  alu_res = 32'd0;
            default: alu_res = 32'd0;
        endcase
    end

    assign alu_out.ctl  = ctl_in;
    assign alu_out.alu  = alu_res;
    assign alu_out.zero = (alu_res == 32'd0);

    assign bubble.ctl  = '0;
    assign bubble.alu  = 32'd0;
    assign bubble.zero = 1'b1;

`ifdef EX_MUL_EN
    logic        mul_busy;
    logic        mul_last;
    logic [31:0] mul_product;
    ctl_t        hold_q;

    ex_mul_seq u_mul (
        .clk       (clk),
        .s         (s),
        .start_i   (mul_req),
        .flush_i   (flush),
        .a_i       (op_a),
        .b_i       (op_b),
        .busy_o    (mul_busy),
        .last_o    (mul_last),
        .product_o (mul_product)
    );

    // Bundle of the multiply in flight; upstream moves on before the result is written.
    always_ff @(posedge clk or negedge s) begin
        if (!s) begin
            hold_q <= '0;
        end else if (!flush && !mul_busy && mul_req) begin
            hold_q <= ctl_in;
        end
    end

    assign stall = s && !flush && (mul_busy ? !mul_last : mul_req);

    always_comb begin
        out_d = bubble;
        if (!flush) begin
            if (mul_busy) begin
                if (mul_last) begin
                    out_d.ctl  = hold_q;
                    out_d.alu  = mul_product;
                    out_d.zero = (mul_product == 32'd0);
                end
            end else if (!mul_req) begin
                out_d = alu_out;
            end
        end
    end
`else
    assign stall = 1'b0;

    always_comb begin
        out_d = bubble;
        if (!flush) begin
            out_d = alu_out;
        end
    end
`endif

    always_ff @(posedge clk or negedge s) begin
        if (!s) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign rf_wrm = out_q.ctl.rf_wr;
    assign dm_wrm = out_q.ctl.dm_wr;
    assign m3selm = out_q.ctl.m3sel;
    assign rtM    = out_q.ctl.rt;
    assign rdM    = out_q.ctl.rd;
    assign aluM   = out_q.alu;
    assign zeroM  = out_q.zero;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; multiplier steps run when EX_MUL_EN is defined.
module tb_ex_stage;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic        clk = 1'b0;
    logic        s;
    logic        flush;
    logic        rf_wre, dm_wre, m1sele, m2sele, m3sele;
    logic [2:0]  ALUope;
    logic [31:0] exte, rsE, rtE, rdE;
    logic        rf_wrm, dm_wrm, m3selm, zeroM, stall;
    logic [31:0] aluM, rtM, rdM;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk    (clk),
        .s      (s),
        .flush  (flush),
        .rf_wre (rf_wre),
        .dm_wre (dm_wre),
        .m1sele (m1sele),
        .m2sele (m2sele),
        .m3sele (m3sele),
        .ALUope (ALUope),
        .exte   (exte),
        .rsE    (rsE),
        .rtE    (rtE),
        .rdE    (rdE),
        .rf_wrm (rf_wrm),
        .dm_wrm (dm_wrm),
        .m3selm (m3selm),
        .aluM   (aluM),
        .rtM    (rtM),
        .rdM    (rdM),
        .zeroM  (zeroM),
        .stall  (stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic m1, input logic m2, input logic m3,
                         input logic rfw, input logic dmw, input logic [31:0] rd);
        ALUope = op; rsE = a; rtE = b; exte = imm;
        m1sele = m1; m2sele = m2; m3sele = m3;
        rf_wre = rfw; dm_wre = dmw; rdE = rd;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".alu"},  aluM,   32'd0);
        chk({tag, ".rfw"},  rf_wrm, 32'd0);
        chk({tag, ".zero"}, zeroM,  32'd1);
    endtask

    initial begin
        s = 1'b0;
        flush = 1'b0;
        drive(OP_ADD, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        #2;
        chk("rst.alu",   aluM,   32'd0);
        chk("rst.zero",  zeroM,  32'd0);
        chk("rst.rfw",   rf_wrm, 32'd0);
        chk("rst.dmw",   dm_wrm, 32'd0);
        chk("rst.stall", stall,  32'd0);
        @(negedge clk);
        s = 1'b1;

        drive(OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd5);
        cyc();
        $display("add FFFFFFFF+1 -> aluM=%h zeroM=%b", aluM, zeroM);
        chk("add_wrap.alu",  aluM,   32'd0);
        chk("add_wrap.zero", zeroM,  32'd1);
        chk("add_wrap.rfw",  rf_wrm, 32'd1);
        chk("add_wrap.rd",   rdM,    32'd5);

        drive(OP_SLT, 32'h8000_0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd6);
        cyc();
        $display("slt 80000000<0 -> aluM=%h", aluM);
        chk("slt_neg.alu",  aluM,  32'd1);
        chk("slt_neg.zero", zeroM, 32'd0);

        drive(OP_OR, 32'h0000_FFFF, 32'h0000_CAFE, 32'h0000_1234, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'd7);
        cyc();
        $display("or imm/zero -> aluM=%h rtM=%h m3selm=%b", aluM, rtM, m3selm);
        chk("or_imm.alu", aluM,   32'h0000_1234);
        chk("or_imm.rt",  rtM,    32'h0000_CAFE);
        chk("or_imm.m3",  m3selm, 32'd1);

        drive(OP_SUB, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd8);
        cyc();
        $display("sub 5-3 -> aluM=%h dm_wrm=%b", aluM, dm_wrm);
        chk("sub.alu", aluM,   32'd2);
        chk("sub.dmw", dm_wrm, 32'd1);
        chk("sub.rfw", rf_wrm, 32'd0);

        drive(OP_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1);
        cyc();
        $display("xor -> aluM=%h", aluM);
        chk("xor.alu", aluM, 32'h5555_5555);

        drive(OP_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1);
        cyc();
        $display("and -> aluM=%h", aluM);
        chk("and.alu", aluM, 32'hF000_F000);

        drive(OP_SLL, 32'h8000_0001, 32'h0000_0024, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1);
        cyc();
        $display("sll 80000001<<4 -> aluM=%h", aluM);
        chk("sll.alu", aluM, 32'h0000_0010);

        drive(OP_SLT, 32'd5, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1);
        cyc();
        $display("slt 5<-1 -> aluM=%h", aluM);
        chk("slt_pos.alu", aluM, 32'd0);

        drive(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1);
        cyc();
        $display("add 7FFFFFFF+1 -> aluM=%h", aluM);
        chk("add_ovf.alu", aluM, 32'h8000_0000);

        // Mul with writes disabled is a nop in every build.
        drive(OP_MUL, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd2);
        #1;
        chk("mulnop.stall", stall, 32'd0);
        cyc();
        $display("mul rf_wre=0 -> aluM=%h stall=%b", aluM, stall);
        chk("mulnop.alu",  aluM,  32'd0);
        chk("mulnop.zero", zeroM, 32'd1);

        drive(OP_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd3);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        $display("flushed add -> aluM=%h rf_wrm=%b", aluM, rf_wrm);
        chk_bubble("flush_add");
        chk("flush_add.dmw", dm_wrm, 32'd0);

`ifdef EX_MUL_EN
        drive(OP_MUL, 32'h0001_0001, 32'h0001_0001, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd9);
        #1;
        chk("mul.stall0", stall, 32'd1);
        for (int k = 1; k <= 32; k++) begin
            cyc();
            chk_bubble($sformatf("mul.c%0d", k));
            chk($sformatf("mul.stall%0d", k), stall, (k < 32) ? 32'd1 : 32'd0);
        end
        drive(OP_ADD, 32'd2, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd4);
        cyc();
        $display("mul 10001*10001 -> aluM=%h rf_wrm=%b rdM=%h", aluM, rf_wrm, rdM);
        chk("mul.alu",  aluM,   32'h0002_0001);
        chk("mul.rfw",  rf_wrm, 32'd1);
        chk("mul.rd",   rdM,    32'd9);
        chk("mul.rt",   rtM,    32'h0001_0001);
        chk("mul.m3",   m3selm, 32'd1);
        chk("mul.zero", zeroM,  32'd0);
        #1;
        chk("mul.stall33", stall, 32'd0);
        cyc();
        $display("add after mul -> aluM=%h", aluM);
        chk("mul_next.alu", aluM, 32'd5);

        drive(OP_MUL, 32'd6, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd10);
        for (int k = 1; k <= 15; k++) cyc();
        chk("mulfl.stall15", stall, 32'd1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(OP_SUB, 32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd11);
        #1;
        $display("flush mid-mul -> stall=%b aluM=%h", stall, aluM);
        chk("mulfl.stall16", stall, 32'd0);
        chk_bubble("mulfl.out");
        cyc();
        $display("sub after flush -> aluM=%h", aluM);
        chk("mulfl.sub", aluM,   32'd2);
        chk("mulfl.rfw", rf_wrm, 32'd1);
`else
        drive(OP_MUL, 32'd5, 32'd6, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2);
        #1;
        chk("muloff.stall", stall, 32'd0);
        cyc();
        $display("mul (no multiplier) -> aluM=%h stall=%b", aluM, stall);
        chk("muloff.alu",  aluM,  32'd0);
        chk("muloff.zero", zeroM, 32'd1);
`endif

        // Reset in cycle 10 of a 7*9 multiply.
        drive(OP_MUL, 32'd7, 32'd9, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd12);
        for (int k = 1; k <= 10; k++) cyc();
        s = 1'b0;
        #1;
        $display("reset mid-mul -> aluM=%h stall=%b zeroM=%b", aluM, stall, zeroM);
        chk("rstmul.alu",   aluM,   32'd0);
        chk("rstmul.zero",  zeroM,  32'd0);
        chk("rstmul.rfw",   rf_wrm, 32'd0);
        chk("rstmul.dmw",   dm_wrm, 32'd0);
        chk("rstmul.m3",    m3selm, 32'd0);
        chk("rstmul.rd",    rdM,    32'd0);
        chk("rstmul.stall", stall,  32'd0);
        drive(OP_ADD, 32'd10, 32'd20, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd13);
        cyc();
        chk("rstmul.held", aluM, 32'd0);
        #3;
        s = 1'b1;
        cyc();
        $display("add after reset -> aluM=%h rf_wrm=%b", aluM, rf_wrm);
        chk("rstmul.add",   aluM,   32'd30);
        chk("rstmul.addwr", rf_wrm, 32'd1);
        chk("rstmul.addz",  zeroM,  32'd0);
        #1;
        chk("rstmul.stall2", stall, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
